// File: rtl/cla_pipe_addsub_pkg.sv
// Shared types and defaults for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int CLA_WIDTH = 16;
    localparam int CLA_GROUP = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
interface cla_pipe_addsub_if
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_s, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_s, out_cout, out_ovf, out_zero
    );

endinterface

// File: rtl/cla_pipe_addsub_group.sv
// Combinational lookahead slice: sum, group propagate/generate,
// carry out and carry into the slice MSB.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             p,
    output logic             g,
    output logic             cout,
    output logic             cmsb
);

    logic [GROUP-1:0] pi;
    logic [GROUP-1:0] gi;
    logic [GROUP:0]   c;

    assign pi = a ^ b;
    assign gi = a & b;

    // Each carry is a flat sum of products over the bits below it.
    always_comb begin
        logic acc;
        logic pp;
        c    = '0;
        c[0] = cin;
        p    = 1'b0;
        g    = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            acc = gi[i];
            pp  = pi[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & gi[j]);
                pp  = pp & pi[j];
            end
            c[i+1] = acc | (pp & cin);
            if (i == GROUP - 1) begin
                g = acc;
                p = pp;
            end
        end
        s    = pi ^ c[GROUP-1:0];
        cout = c[GROUP];
        cmsb = c[GROUP-1];
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor: one GROUP-bit slice resolved per stage,
// operands skewed in, sums de-skewed out, global stall on backpressure.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input logic             Clk,
    input logic             Reset_n,
    cla_pipe_addsub_if.slave io
);

    localparam int NSLICE = WIDTH / GROUP;

    typedef logic [GROUP-1:0] sl_t;

    if (WIDTH % GROUP != 0) begin : g_bad_cfg
        $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP");
    end

    logic   v_q  [NSLICE];
    op_e    op_q [NSLICE];
    logic   c_q  [NSLICE];
    sl_t    a_q  [NSLICE][NSLICE];
    sl_t    b_q  [NSLICE][NSLICE];
    sl_t    s_q  [NSLICE][NSLICE];
    flags_t flg_q;
    logic   rdy_q;

    sl_t  ga  [NSLICE];
    sl_t  gbr [NSLICE];
    sl_t  gb  [NSLICE];
    sl_t  gs  [NSLICE];
    op_e  gop [NSLICE];
    logic gci [NSLICE];
    logic gp  [NSLICE];
    logic gg  [NSLICE];
    logic gco [NSLICE];
    logic gcm [NSLICE];
    logic gcy [NSLICE];

    logic             adv;
    logic             acc;
    logic [WIDTH-1:0] fin_s;
    logic [WIDTH-1:0] nxt_s;

    assign adv = !v_q[NSLICE-1] || io.out_ready;
    assign acc = io.in_valid && adv && rdy_q;

    always_comb begin
        ga[0]  = io.in_a[GROUP-1:0];
        gbr[0] = io.in_b[GROUP-1:0];
        gop[0] = op_e'(io.in_sub);
        gci[0] = io.in_sub;
        for (int k = 1; k < NSLICE; k++) begin
            ga[k]  = a_q[k-1][k];
            gbr[k] = b_q[k-1][k];
            gop[k] = op_q[k-1];
            gci[k] = c_q[k-1];
        end
        for (int k = 0; k < NSLICE; k++) begin
            gb[k]  = (gop[k] == OP_SUB) ? ~gbr[k] : gbr[k];
            gcy[k] = gg[k] | (gp[k] & gci[k]);
        end
    end

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a    (ga[k]),
            .b    (gb[k]),
            .cin  (gci[k]),
            .s    (gs[k]),
            .p    (gp[k]),
            .g    (gg[k]),
            .cout (gco[k]),
            .cmsb (gcm[k])
        );
    end

    // Sum about to enter the output register, used for the zero flag.
    if (NSLICE == 1) begin : g_nxt1
        assign nxt_s = gs[0];
    end else begin : g_nxtn
        always_comb begin
            nxt_s = '0;
            for (int j = 0; j < NSLICE - 1; j++) begin
                nxt_s[j*GROUP +: GROUP] = s_q[NSLICE-2][j];
            end
            nxt_s[(NSLICE-1)*GROUP +: GROUP] = gs[NSLICE-1];
        end
    end

    always_comb begin
        fin_s = '0;
        for (int j = 0; j < NSLICE; j++) begin
            fin_s[j*GROUP +: GROUP] = s_q[NSLICE-1][j];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rdy_q <= 1'b0;
            flg_q <= '0;
            for (int k = 0; k < NSLICE; k++) begin
                v_q[k]  <= 1'b0;
                op_q[k] <= OP_ADD;
                c_q[k]  <= 1'b0;
                for (int j = 0; j < NSLICE; j++) begin
                    a_q[k][j] <= '0;
                    b_q[k][j] <= '0;
                    s_q[k][j] <= '0;
                end
            end
        end else begin
            rdy_q <= 1'b1;
            if (adv) begin
                v_q[0]  <= acc;
                op_q[0] <= op_e'(io.in_sub);
                for (int j = 1; j < NSLICE; j++) begin
                    a_q[0][j] <= io.in_a[j*GROUP +: GROUP];
                    b_q[0][j] <= io.in_b[j*GROUP +: GROUP];
                end
                for (int k = 0; k < NSLICE; k++) begin
                    c_q[k]    <= gcy[k];
                    s_q[k][k] <= gs[k];
                end
                for (int k = 1; k < NSLICE; k++) begin
                    v_q[k]  <= v_q[k-1];
                    op_q[k] <= op_q[k-1];
                    for (int j = 0; j < NSLICE; j++) begin
                        if (j < k) begin
                            s_q[k][j] <= s_q[k-1][j];
                        end else if (j > k) begin
                            a_q[k][j] <= a_q[k-1][j];
                            b_q[k][j] <= b_q[k-1][j];
                        end
                    end
                end
                flg_q.cout <= gco[NSLICE-1];
                flg_q.ovf  <= gco[NSLICE-1] ^ gcm[NSLICE-1];
                flg_q.zero <= (nxt_s == '0);
            end
        end
    end

    assign io.in_ready  = adv && rdy_q;
    assign io.out_valid = v_q[NSLICE-1];
    assign io.out_s     = fin_s;
    assign io.out_cout  = flg_q.cout;
    assign io.out_ovf   = flg_q.ovf;
    assign io.out_zero  = flg_q.zero;

endmodule
